// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data-port SRAM responder.
package data_sram_responder_pkg;

  typedef enum logic [1:0] {
    DSR_IDLE = 2'd0,
    DSR_WAIT = 2'd1,
    DSR_RESP = 2'd2
  } dsr_state_t;

  localparam logic [3:0] WEN_NONE = 4'b0000;
  localparam logic [3:0] WEN_WORD = 4'b1111;

  // Word as it reads after a byte-enabled write of new_word over old_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  wen);
    logic [31:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (wen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// SRAM-like data port: address handshake followed by a one-cycle data response.
interface data_sram_responder_if;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wen, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wen, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_sram_responder_byte_en_ram.sv
// Word RAM with per-byte write enables and asynchronous read; contents survive reset.
module byte_en_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU data port: one request at a time, response
// returned LATENCY wait cycles after acceptance.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  data_sram_responder_if.slave   bus
);

  localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dsr_state_t        state;
  dsr_state_t        state_next;
  logic [3:0]        wait_cnt;
  logic [31:0]       rdata_q;
  logic              addr_ok;
  logic              data_ok;
  logic              accept;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        ram_we;
  logic [31:0]       ram_rdata;
  logic              unused_addr_bits;

  assign idx              = bus.data_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.data_addr[31:ADDR_W+2], bus.data_addr[1:0]};

  always_comb begin
    state_next = state;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    unique case (state)
      DSR_IDLE: begin
        addr_ok = resetn;
        if (bus.data_req && resetn)
          state_next = (LATENCY > 0) ? DSR_WAIT : DSR_RESP;
      end
      DSR_WAIT: begin
        if (wait_cnt == 4'd0) state_next = DSR_RESP;
      end
      DSR_RESP: begin
        data_ok    = resetn;
        state_next = DSR_IDLE;
      end
      default: state_next = DSR_IDLE;
    endcase
  end

  assign accept = bus.data_req & addr_ok;
  assign ram_we = accept ? bus.data_wen : WEN_NONE;

  byte_en_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (idx),
    .we    (ram_we),
    .wdata (bus.data_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= DSR_IDLE;
    else         state <= state_next;
  end

  // The response word is captured pre-merged so a write returns the word it leaves behind.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
      rdata_q  <= '0;
    end else if (accept) begin
      wait_cnt <= WAIT_LOAD;
      rdata_q  <= byte_merge(ram_rdata, bus.data_wdata, bus.data_wen);
    end else if (state == DSR_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign bus.data_addr_ok = addr_ok;
  assign bus.data_data_ok = data_ok;
  assign bus.data_rdata   = data_ok ? rdata_q : '0;

endmodule
